// File: rtl/numberle_pkg.sv
// Shared types and constants for the Numberle game controller.
// Feedback encoding: one 3-bit group per digit, exactly one bit set.
package numberle_pkg;

   typedef enum logic [2:0] {
      ST_SET   = 3'd0,
      ST_GUESS = 3'd1,
      ST_CHECK = 3'd2,
      ST_WIN   = 3'd3,
      ST_LOSE  = 3'd4
   } state_e;

   localparam logic [3:0] BLANK = 4'hF;

   localparam int FB_LT = 2;
   localparam int FB_EQ = 1;
   localparam int FB_GT = 0;

   function automatic logic [2:0] digit_feedback(input logic [3:0] s, input logic [3:0] g);
      logic [2:0] fb;
      fb = 3'b000;
      if (s < g) begin
         fb[FB_LT] = 1'b1;
      end else if (s == g) begin
         fb[FB_EQ] = 1'b1;
      end else begin
         fb[FB_GT] = 1'b1;
      end
      return fb;
   endfunction

endpackage

// File: rtl/numberle_btn_edge.sv
// Two-flop synchroniser followed by a rising-edge detector.
// pulse is high for exactly one clock per rising edge of btn_in.
module numberle_btn_edge
   import numberle_pkg::*;
(
   input  logic clock,
   input  logic reset_n,
   input  logic btn_in,
   output logic pulse
);

   // [0],[1] synchronise; [2] remembers the previous synchronised level
   logic [2:0] sync_q;
   logic [2:0] sync_d;

   always_comb begin
      sync_d = {sync_q[1:0], btn_in};
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= 3'b000;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign pulse = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/numberle_game_ctrl.sv
// Numberle game controller: secret/guess entry, per-digit compare, try counting
// and multiplexed seven-segment display scanning, all in one clock domain.
module numberle_game_ctrl
   import numberle_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int MAX_TRIES  = 7,
   parameter int SCAN_DIV   = 100000
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic                      key_valid,
   input  logic [3:0]                key_value,
   input  logic                      btn_next,
   input  logic                      btn_submit,
   input  logic                      btn_restart,
   output logic [NUM_DIGITS-1:0]     anode,
   output logic [3:0]                hex_out,
   output logic                      dp,
   output logic [3*NUM_DIGITS-1:0]   led,
   output logic [3:0]                tries_used,
   output logic                      win,
   output logic                      lose
);

   localparam int CUR_W  = $clog2(NUM_DIGITS);
   localparam int TICK_W = $clog2(SCAN_DIV);
   localparam logic [CUR_W-1:0]      LAST_DIGIT = CUR_W'(NUM_DIGITS - 1);
   localparam logic [TICK_W-1:0]     LAST_TICK  = TICK_W'(SCAN_DIV - 1);
   localparam logic [3:0]            MAX_T      = 4'(MAX_TRIES);
   localparam logic [NUM_DIGITS-1:0] ANODE_TOP  = {1'b1, {(NUM_DIGITS-1){1'b0}}};

   typedef logic [NUM_DIGITS-1:0][3:0] digits_t;
   localparam digits_t ALL_BLANK = {NUM_DIGITS{BLANK}};

   logic next_p;
   logic submit_p;
   logic restart_p;

   state_e                  state_q, state_d;
   digits_t                 secret_q, secret_d;
   digits_t                 guess_q, guess_d;
   logic [CUR_W-1:0]        cursor_q, cursor_d;
   logic [3:0]              tries_q, tries_d;
   logic [3*NUM_DIGITS-1:0] led_q, led_d;
   logic                    win_q, win_d;
   logic                    lose_q, lose_d;

   logic [TICK_W-1:0]       tick_q, tick_d;
   logic [CUR_W-1:0]        scan_idx_q, scan_idx_d;
   logic                    scan_on_q, scan_on_d;
   logic [NUM_DIGITS-1:0]   anode_q, anode_d;
   logic [3:0]              hex_q, hex_d;
   logic                    dp_q, dp_d;

   logic                    secret_full;
   logic                    guess_full;
   logic                    all_eq;
   logic [3*NUM_DIGITS-1:0] fb_vec;
   logic                    key_ok;
   logic [CUR_W-1:0]        cursor_inc;
   digits_t                 disp_buf;

   numberle_btn_edge u_next (
      .clock   (clock),
      .reset_n (reset_n),
      .btn_in  (btn_next),
      .pulse   (next_p)
   );

   numberle_btn_edge u_submit (
      .clock   (clock),
      .reset_n (reset_n),
      .btn_in  (btn_submit),
      .pulse   (submit_p)
   );

   numberle_btn_edge u_restart (
      .clock   (clock),
      .reset_n (reset_n),
      .btn_in  (btn_restart),
      .pulse   (restart_p)
   );

   always_comb begin
      secret_full = 1'b1;
      guess_full  = 1'b1;
      all_eq      = 1'b1;
      fb_vec      = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (secret_q[i] == BLANK) secret_full = 1'b0;
         if (guess_q[i] == BLANK)  guess_full  = 1'b0;
         if (secret_q[i] != guess_q[i]) all_eq = 1'b0;
         fb_vec[3*i +: 3] = digit_feedback(secret_q[i], guess_q[i]);
      end
   end

   always_comb begin
      state_d    = state_q;
      secret_d   = secret_q;
      guess_d    = guess_q;
      cursor_d   = cursor_q;
      tries_d    = tries_q;
      led_d      = led_q;
      key_ok     = key_valid && (key_value <= 4'd9);
      cursor_inc = (cursor_q == LAST_DIGIT) ? '0 : cursor_q + 1'b1;

      if (restart_p) begin
         state_d  = ST_SET;
         secret_d = ALL_BLANK;
         guess_d  = ALL_BLANK;
         cursor_d = '0;
         tries_d  = 4'd0;
         led_d    = '0;
      end else begin
         case (state_q)
            ST_SET: begin
               if (submit_p) begin
                  if (secret_full) begin
                     guess_d  = ALL_BLANK;
                     cursor_d = '0;
                     state_d  = ST_GUESS;
                  end
               end else begin
                  // key lands at the old cursor even when next moves it this cycle
                  if (key_ok) secret_d[cursor_q] = key_value;
                  if (next_p) cursor_d = cursor_inc;
               end
            end
            ST_GUESS: begin
               if (submit_p) begin
                  if (guess_full) state_d = ST_CHECK;
               end else begin
                  if (key_ok) guess_d[cursor_q] = key_value;
                  if (next_p) cursor_d = cursor_inc;
               end
            end
            ST_CHECK: begin
               led_d   = fb_vec;
               tries_d = (tries_q < MAX_T) ? tries_q + 4'd1 : tries_q;
               if (all_eq) begin
                  led_d   = '1;
                  state_d = ST_WIN;
               end else if ((tries_q + 4'd1) >= MAX_T) begin
                  state_d = ST_LOSE;
               end else begin
                  guess_d  = ALL_BLANK;
                  cursor_d = '0;
                  state_d  = ST_GUESS;
               end
            end
            ST_WIN: begin
               led_d = '1;
            end
            ST_LOSE: begin
               led_d = led_q;
            end
            default: begin
               state_d = ST_SET;
            end
         endcase
      end

      win_d  = (state_d == ST_WIN);
      lose_d = (state_d == ST_LOSE);
   end

   // Display path: free-running scan, blank until the first slot advance
   always_comb begin
      tick_d     = (tick_q == LAST_TICK) ? '0 : tick_q + 1'b1;
      scan_idx_d = scan_idx_q;
      scan_on_d  = scan_on_q;
      if (tick_q == LAST_TICK) begin
         scan_idx_d = (scan_idx_q == LAST_DIGIT) ? '0 : scan_idx_q + 1'b1;
         scan_on_d  = 1'b1;
      end

      disp_buf = ((state_q == ST_GUESS) || (state_q == ST_CHECK)) ? guess_q : secret_q;
      anode_d  = '1;
      hex_d    = BLANK;
      dp_d     = 1'b1;
      if (scan_on_q) begin
         anode_d = ~(ANODE_TOP >> scan_idx_q);
         hex_d   = disp_buf[scan_idx_q];
         if (state_q == ST_WIN) begin
            dp_d = 1'b0;
         end else if (((state_q == ST_SET) || (state_q == ST_GUESS)) && (cursor_q == scan_idx_q)) begin
            dp_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_SET;
         secret_q   <= ALL_BLANK;
         guess_q    <= ALL_BLANK;
         cursor_q   <= '0;
         tries_q    <= 4'd0;
         led_q      <= '0;
         win_q      <= 1'b0;
         lose_q     <= 1'b0;
         tick_q     <= '0;
         scan_idx_q <= '0;
         scan_on_q  <= 1'b0;
         anode_q    <= '1;
         hex_q      <= BLANK;
         dp_q       <= 1'b1;
      end else begin
         state_q    <= state_d;
         secret_q   <= secret_d;
         guess_q    <= guess_d;
         cursor_q   <= cursor_d;
         tries_q    <= tries_d;
         led_q      <= led_d;
         win_q      <= win_d;
         lose_q     <= lose_d;
         tick_q     <= tick_d;
         scan_idx_q <= scan_idx_d;
         scan_on_q  <= scan_on_d;
         anode_q    <= anode_d;
         hex_q      <= hex_d;
         dp_q       <= dp_d;
      end
   end

   assign anode      = anode_q;
   assign hex_out    = hex_q;
   assign dp         = dp_q;
   assign led        = led_q;
   assign tries_used = tries_q;
   assign win        = win_q;
   assign lose       = lose_q;

endmodule

// File: tb/tb_numberle_game_ctrl.sv
// Scoreboard bench for numberle_game_ctrl: directed scenarios plus random games
// checked against a rule-level model of the game.
module tb_numberle_game_ctrl;

   localparam int ND = 4;
   localparam int MT = 3;
   localparam int SD = 4;
   localparam int B_NEXT = 0;
   localparam int B_SUB  = 1;
   localparam int B_RST  = 2;

   logic            clock = 1'b0;
   logic            reset_n = 1'b0;
   logic            key_valid = 1'b0;
   logic [3:0]      key_value = 4'd0;
   logic            btn_next = 1'b0;
   logic            btn_submit = 1'b0;
   logic            btn_restart = 1'b0;
   logic [ND-1:0]   anode;
   logic [3:0]      hex_out;
   logic            dp;
   logic [3*ND-1:0] led;
   logic [3:0]      tries_used;
   logic            win;
   logic            lose;

   typedef logic [ND-1:0][3:0] num_t;
   typedef struct packed {
      logic [3*ND-1:0] led;
      logic [3:0]      tries;
      logic            win;
      logic            lose;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       mon_exp;
   exp_t       mon_got;
   int         checks = 0;
   int         errors = 0;
   int         m_tries = 0;
   bit         m_over = 1'b0;
   logic [3:0] prev_tries = 4'd0;

   numberle_game_ctrl #(
      .NUM_DIGITS (ND),
      .MAX_TRIES  (MT),
      .SCAN_DIV   (SD)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .key_valid   (key_valid),
      .key_value   (key_value),
      .btn_next    (btn_next),
      .btn_submit  (btn_submit),
      .btn_restart (btn_restart),
      .anode       (anode),
      .hex_out     (hex_out),
      .dp          (dp),
      .led         (led),
      .tries_used  (tries_used),
      .win         (win),
      .lose        (lose)
   );

   always #5 clock = ~clock;

   // Monitor: every committed guess shows up as tries_used stepping by one
   always @(negedge clock) begin
      if (reset_n && (tries_used == prev_tries + 4'd1)) begin
         checks++;
         mon_got = '{led: led, tries: tries_used, win: win, lose: lose};
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_result got led=%h tries=%0d win=%b lose=%b",
                     led, tries_used, win, lose);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_got !== mon_exp) begin
               errors++;
               $display("FAIL result got led=%h tries=%0d win=%b lose=%b want led=%h tries=%0d win=%b lose=%b",
                        mon_got.led, mon_got.tries, mon_got.win, mon_got.lose,
                        mon_exp.led, mon_exp.tries, mon_exp.win, mon_exp.lose);
            end
         end
      end
      prev_tries = tries_used;
   end

   initial begin
      #400000;
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", nm, got, want);
      end
   endtask

   task automatic set_btn(input int b, input logic v);
      case (b)
         B_NEXT:  btn_next = v;
         B_SUB:   btn_submit = v;
         default: btn_restart = v;
      endcase
   endtask

   // Rising edge acts three clocks later; the key strobe is aligned to that clock.
   task automatic press(input int b, input logic kv, input logic [3:0] kval);
      set_btn(b, 1'b1);
      tick();
      tick();
      key_valid = kv;
      key_value = kval;
      tick();
      key_valid = 1'b0;
      repeat (3) tick();
      set_btn(b, 1'b0);
      repeat (3) tick();
   endtask

   task automatic key_only(input logic [3:0] v);
      key_valid = 1'b1;
      key_value = v;
      tick();
      key_valid = 1'b0;
      tick();
   endtask

   task automatic enter_num(input num_t n, input bit junk);
      for (int i = 0; i < ND; i++) begin
         if (junk && ($urandom_range(0, 2) == 0)) key_only(4'(10 + $urandom_range(0, 5)));
         press(B_NEXT, 1'b1, n[i]);
      end
   endtask

   task automatic do_restart();
      press(B_RST, 1'b0, 4'd0);
      m_tries = 0;
      m_over  = 1'b0;
   endtask

   task automatic model_submit(input num_t s, input num_t g);
      exp_t e;
      bit   all;
      e   = '0;
      all = 1'b1;
      m_tries++;
      for (int i = 0; i < ND; i++) begin
         if (s[i] < g[i])       e.led[3*i+2] = 1'b1;
         else if (s[i] == g[i]) e.led[3*i+1] = 1'b1;
         else                   e.led[3*i]   = 1'b1;
         if (s[i] != g[i]) all = 1'b0;
      end
      if (all) e.led = '1;
      e.tries = 4'(m_tries);
      e.win   = all;
      e.lose  = !all && (m_tries == MT);
      m_over  = all || (m_tries == MT);
      exp_q.push_back(e);
   endtask

   task automatic wait_drain(input string nm);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 30) begin
         tick();
         n++;
      end
      check(nm, exp_q.size(), 0);
   endtask

   task automatic submit_guess(input num_t s, input num_t g, input bit junk);
      enter_num(g, junk);
      if (!m_over) model_submit(s, g);
      press(B_SUB, 1'b0, 4'd0);
      wait_drain("result_drain");
   endtask

   task automatic check_slot(input string nm, input int d, input logic exp_dp, input logic [3:0] exp_hex);
      logic [3:0] want;
      int         n;
      want = ~(4'b1000 >> d);
      n    = 0;
      do begin
         @(negedge clock);
         n++;
      end while (anode !== want && n < 64);
      if (anode !== want) begin
         check({nm, "_anode"}, anode, want);
      end else begin
         check({nm, "_dp"}, dp, exp_dp);
         check({nm, "_hex"}, hex_out, exp_hex);
      end
   endtask

   function automatic num_t mk(input int d0, input int d1, input int d2, input int d3);
      num_t n;
      n[0] = 4'(d0);
      n[1] = 4'(d1);
      n[2] = 4'(d2);
      n[3] = 4'(d3);
      return n;
   endfunction

   initial begin
      num_t s;
      num_t g;

      // Reset values
      repeat (3) tick();
      check("rst_anode", anode, 4'b1111);
      check("rst_hex", hex_out, 4'hF);
      check("rst_dp", dp, 1'b1);
      check("rst_led", led, 12'h000);
      check("rst_tries", tries_used, 4'd0);
      check("rst_win", win, 1'b0);
      check("rst_lose", lose, 1'b0);
      reset_n = 1'b1;
      tick();

      // Exact match on the first guess
      s = mk(1, 2, 3, 4);
      enter_num(s, 1'b0);
      press(B_SUB, 1'b0, 4'd0);
      submit_guess(s, mk(1, 2, 3, 4), 1'b0);
      check("win_flag", win, 1'b1);
      check("win_led", led, 12'hFFF);
      enter_num(mk(5, 5, 5, 5), 1'b0);
      press(B_SUB, 1'b0, 4'd0);
      check("win_hold_tries", tries_used, 4'd1);
      check("win_hold_led", led, 12'hFFF);
      check_slot("win_slot2", 2, 1'b0, 4'd3);
      do_restart();
      check("rst1_tries", tries_used, 4'd0);
      check("rst1_win", win, 1'b0);
      check("rst1_led", led, 12'h000);

      // Mixed feedback, then guess is blanked for the next try
      s = mk(5, 5, 5, 5);
      enter_num(s, 1'b1);
      press(B_SUB, 1'b0, 4'd0);
      submit_guess(s, mk(3, 5, 7, 5), 1'b1);
      check("mix_led", led, 12'h511);
      check("mix_win", win, 1'b0);
      check_slot("mix_blank", 1, 1'b1, 4'hF);

      // Asynchronous reset in the middle of entering a guess
      press(B_NEXT, 1'b1, 4'd6);
      press(B_NEXT, 1'b1, 4'd7);
      reset_n = 1'b0;
      #1;
      check("arst_tries", tries_used, 4'd0);
      check("arst_led", led, 12'h000);
      check("arst_anode", anode, 4'b1111);
      check("arst_hex", hex_out, 4'hF);
      check("arst_dp", dp, 1'b1);
      m_tries = 0;
      m_over  = 1'b0;
      repeat (2) tick();
      reset_n = 1'b1;
      @(negedge clock);
      check("arst_anode_after", anode, 4'b1111);
      tick();

      // Incomplete guess, invalid key, key+next wrap and cursor dp
      s = mk(9, 0, 8, 1);
      enter_num(s, 1'b0);
      press(B_SUB, 1'b0, 4'd0);
      press(B_NEXT, 1'b1, 4'd1);
      press(B_NEXT, 1'b1, 4'd2);
      press(B_NEXT, 1'b0, 4'd0);
      press(B_NEXT, 1'b1, 4'd4);
      press(B_SUB, 1'b0, 4'd0);
      check("blank_submit_tries", tries_used, 4'd0);
      key_only(4'hB);
      check_slot("cursor0", 0, 1'b0, 4'd1);
      check_slot("slot1", 1, 1'b1, 4'd2);
      press(B_NEXT, 1'b0, 4'd0);
      press(B_NEXT, 1'b0, 4'd0);
      press(B_NEXT, 1'b1, 4'd3);
      press(B_NEXT, 1'b0, 4'd0);
      model_submit(s, mk(1, 2, 3, 4));
      press(B_SUB, 1'b0, 4'd0);
      wait_drain("fill_drain");

      // Run out of tries
      submit_guess(s, mk(1, 1, 1, 1), 1'b0);
      submit_guess(s, mk(2, 2, 2, 2), 1'b0);
      check("lose_flag", lose, 1'b1);
      check("lose_tries", tries_used, 4'd3);
      enter_num(s, 1'b0);
      press(B_SUB, 1'b0, 4'd0);
      check("lose_hold_tries", tries_used, 4'd3);
      check("lose_hold_win", win, 1'b0);
      check("lose_hold_lose", lose, 1'b1);
      do_restart();
      check("rst2_tries", tries_used, 4'd0);
      check("rst2_lose", lose, 1'b0);
      check("rst2_led", led, 12'h000);

      // Random games
      for (int gm = 0; gm < 6; gm++) begin
         do_restart();
         for (int i = 0; i < ND; i++) s[i] = 4'($urandom_range(0, 9));
         enter_num(s, 1'b1);
         press(B_SUB, 1'b0, 4'd0);
         while (!m_over) begin
            for (int i = 0; i < ND; i++) begin
               g[i] = ($urandom_range(0, 1) == 0) ? s[i] : 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 3) == 0) g = s;
            submit_guess(s, g, 1'b1);
         end
         enter_num(s, 1'b1);
         press(B_SUB, 1'b0, 4'd0);
         check("game_over_tries", tries_used, 32'(m_tries));
      end

      check("queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
